// File: rtl/kevin_pkg.sv
// Shared constants and result record for the Kevin-number stream classifier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package kevin_pkg;

  // Default membership set {1,5,6,7,9,10,12,14} for 4-bit symbols
  localparam logic [15:0] KEVIN_MASK_DEFAULT    = 16'h56E2;
  localparam int          KEVIN_RUN_LEN_DEFAULT = 3;

  // One classified result as held in the output register
  typedef struct packed {
    logic hit;
    logic run;
  } kevin_res_t;

endpackage

// File: rtl/kevin_stream_if.sv
// Handshake bundle between a symbol source, kevin_stream and a result sink.
// Latency: n/a (wires only).
// Backpressure: out_ready from the sink gates in_ready towards the source.
interface kevin_stream_if #(
  parameter int WIDTH = 4
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_hit;
  logic             out_run;

  // Source/sink side (testbench or surrounding logic)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_hit, out_run
  );

  // Classifier side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_hit, out_run
  );

endinterface

// File: rtl/kevin_run_ctr.sv
// Tracks consecutive accepted hits and raises the run alarm at RUN_LEN.
// Latency: run flag is registered, valid the cycle after the accept.
// Backpressure: none; only advances on accept, holds otherwise.
module kevin_run_ctr #(
  parameter int RUN_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic accept,
  input  logic hit,
  output logic run
);

  localparam int CW = $clog2(RUN_LEN + 1);
  localparam logic [CW-1:0] RUN_MAX = CW'(RUN_LEN);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;

  // Next run length: saturating increment on hit, restart on miss
  always_comb begin
    cnt_nxt = cnt_q;
    if (hit) begin
      if (cnt_q != RUN_MAX) begin
        cnt_nxt = cnt_q + 1'b1;
      end
    end else begin
      cnt_nxt = '0;
    end
  end

  // Commit run length and alarm only when a symbol is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run   <= 1'b0;
    end else if (accept) begin
      cnt_q <= cnt_nxt;
      run   <= (cnt_nxt == RUN_MAX);
    end
  end

endmodule

// File: rtl/kevin_stream.sv
// Classifies each accepted symbol against MASK and flags runs of hits.
// Latency: one cycle from accept to result; optional hit_count (KEVIN_HIT_CNT_EN).
// Backpressure: single result register, in_ready = !out_valid || out_ready.
module kevin_stream
  import kevin_pkg::*;
#(
  parameter int                   WIDTH   = 4,
  parameter logic [(1<<WIDTH)-1:0] MASK   = KEVIN_MASK_DEFAULT,
  parameter int                   RUN_LEN = KEVIN_RUN_LEN_DEFAULT,
  parameter int                   CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  kevin_stream_if.slave      s
`ifdef KEVIN_HIT_CNT_EN
  ,
  output logic [CNT_W-1:0]   hit_count
`endif
);

  logic       accept;
  logic       lookup_hit;
  logic       out_valid_q;
  logic       hit_q;
  logic       run_flag;
  kevin_res_t res;

  // Reset blocks acceptance even though in_ready may read high
  assign s.in_ready = !out_valid_q || s.out_ready;
  assign accept     = s.in_valid && s.in_ready && !rst;

  // Membership is a plain table lookup; in_data only matters under accept
  assign lookup_hit = MASK[s.in_data];

  // Result register: load on accept, drop once consumed with nothing new
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      hit_q       <= lookup_hit;
    end else if (s.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  kevin_run_ctr #(
    .RUN_LEN (RUN_LEN)
  ) u_run_ctr (
    .clk    (clk),
    .rst    (rst),
    .accept (accept),
    .hit    (lookup_hit),
    .run    (run_flag)
  );

  assign res         = '{hit: hit_q, run: run_flag};
  assign s.out_valid = out_valid_q;
  assign s.out_hit   = res.hit;
  assign s.out_run   = res.run;

`ifdef KEVIN_HIT_CNT_EN
  // Saturating count of every accepted hit since reset
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count <= '0;
    end else if (accept && lookup_hit && (hit_count != {CNT_W{1'b1}})) begin
      hit_count <= hit_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_kevin_stream.sv
// Randomized and directed checks of kevin_stream against a cycle-level model.
// Latency: n/a.
// Backpressure: out_ready randomized to exercise holding.
module tb_kevin_stream;

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  kevin_stream_if #(.WIDTH(4)) ifc ();
  kevin_stream_if #(.WIDTH(3)) ifc2 ();

`ifdef KEVIN_HIT_CNT_EN
  logic [7:0] hc;
  logic [1:0] hc2;
`endif

  kevin_stream dut (
    .clk (clk),
    .rst (rst),
    .s   (ifc.slave)
`ifdef KEVIN_HIT_CNT_EN
    ,
    .hit_count (hc)
`endif
  );

  kevin_stream #(
    .WIDTH   (3),
    .MASK    (8'h81),
    .RUN_LEN (1),
    .CNT_W   (2)
  ) dut2 (
    .clk (clk),
    .rst (rst2),
    .s   (ifc2.slave)
`ifdef KEVIN_HIT_CNT_EN
    ,
    .hit_count (hc2)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Kevin numbers of the default configuration, listed as a set
  function automatic bit is_kevin(input int v);
    int set_vals[8] = '{1, 5, 6, 7, 9, 10, 12, 14};
    foreach (set_vals[i]) if (set_vals[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Reference state for the default instance
  localparam int RUN_LEN = 3;
  localparam int HMAX    = 255;
  bit m_valid, m_hit, m_run;
  int m_cnt, m_hits;

  // One cycle on the default instance: drive at negedge, check next negedge
  task automatic step(input bit v, input int d, input bit ordy, input bit r);
    bit h;
    ifc.in_valid  = v;
    ifc.in_data   = 4'(d);
    ifc.out_ready = ordy;
    rst           = r;
    #1;
    check("in_ready", ifc.in_ready, int'(!m_valid || ordy));
    if (r) begin
      m_valid = 0; m_hit = 0; m_run = 0; m_cnt = 0; m_hits = 0;
    end else if (v && (!m_valid || ordy)) begin
      h = is_kevin(d);
      m_cnt   = h ? ((m_cnt < RUN_LEN) ? m_cnt + 1 : RUN_LEN) : 0;
      m_hit   = h;
      m_run   = h && (m_cnt == RUN_LEN);
      m_valid = 1;
      if (h && m_hits < HMAX) m_hits++;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    @(negedge clk);
    check("out_valid", ifc.out_valid, int'(m_valid));
    if (m_valid || r) begin
      check("out_hit", ifc.out_hit, int'(m_hit));
      check("out_run", ifc.out_run, int'(m_run));
    end
`ifdef KEVIN_HIT_CNT_EN
    check("hit_count", hc, m_hits);
`endif
  endtask

  task automatic step2(input bit v, input int d, input bit r);
    ifc2.in_valid  = v;
    ifc2.in_data   = 3'(d);
    ifc2.out_ready = 1'b1;
    rst2           = r;
    @(negedge clk);
  endtask

  initial begin
    int e_run[6] = '{0, 0, 1, 1, 0, 0};
    int s_run[6] = '{5, 6, 7, 9, 2, 1};
    int e2_hit[3] = '{1, 1, 0};
    int e2_run[3] = '{1, 1, 0};
    int s2[3] = '{0, 7, 3};

    rst = 1'b1; rst2 = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b1;
    ifc2.in_valid = 1'b0; ifc2.in_data = '0; ifc2.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    m_valid = 0; m_hit = 0; m_run = 0; m_cnt = 0; m_hits = 0;
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_hit", ifc.out_hit, 0);
    check("rst_out_run", ifc.out_run, 0);
`ifdef KEVIN_HIT_CNT_EN
    check("rst_hit_count", hc, 0);
`endif

    // Symbol presented during reset must be dropped
    step(1, 5, 1, 1);
    step(0, 0, 1, 0);

    // Sweep all symbols with the sink always ready
    for (int i = 0; i < 16; i++) begin
      step(1, i, 1, 0);
      check("sweep_hit", ifc.out_hit, int'(is_kevin(i)));
    end

    // Run alarm pattern
    step(1, 2, 1, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, s_run[i], 1, 0);
      check("run_seq", ifc.out_run, e_run[i]);
    end

    // Hold the result for 12 while the sink stalls
    step(1, 12, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 3, 0, 0);
      check("hold_hit", ifc.out_hit, 1);
    end
    step(1, 3, 1, 0);
    check("after_stall_hit", ifc.out_hit, 0);
    step(0, 0, 1, 0);

    // Reset mid-run restarts the run and the hit count
    step(1, 1, 1, 0);
    step(1, 5, 1, 0);
    step(0, 0, 1, 1);
    step(1, 6, 1, 0);
    check("post_rst_run", ifc.out_run, 0);
`ifdef KEVIN_HIT_CNT_EN
    check("post_rst_count", hc, 1);
`endif

    // Randomized traffic with backpressure and occasional reset
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15),
           $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end
    step(0, 0, 1, 0);

    // Narrow instance: 3-bit symbols, set {0,7}, alarm on every hit
    step2(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step2(1, s2[i], 0);
      check("w3_valid", ifc2.out_valid, 1);
      check("w3_hit", ifc2.out_hit, e2_hit[i]);
      check("w3_run", ifc2.out_run, e2_run[i]);
    end
`ifdef KEVIN_HIT_CNT_EN
    step2(0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      step2(1, 7, 0);
      check("sat_count", hc2, (i < 3) ? i + 1 : 3);
    end
`endif
    step2(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/kevin_stream.md
KEVIN_STREAM -- requirements
Module: kevin_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 4, symbol width in bits (1..8).
REQ-002 SHALL have parameter MASK, default 16'h56E2, membership mask of 2**WIDTH bits; bit k set means symbol value k is a Kevin number (default set {1,5,6,7,9,10,12,14}).
REQ-003 SHALL have parameter RUN_LEN, default 3, consecutive-hit threshold (1..255).
REQ-004 SHALL have parameter CNT_W, default 8, hit counter width.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port in_valid  input  1  upstream symbol valid.
REQ-008 SHALL have port in_ready  output  1  block can accept a symbol this cycle.
REQ-009 SHALL have port in_data  input  WIDTH  symbol under test.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_hit  output  1  MASK[symbol] of the held result.
REQ-013 SHALL have port out_run  output  1  run alarm: held result ends a run of at least RUN_LEN consecutive hits.
REQ-014 SHALL have port hit_count  output  CNT_W  total accepted hits (present only with KEVIN_HIT_CNT_EN).

Function
REQ-015 SHALL accept a symbol on a cycle where in_valid and in_ready are both 1 (accept event).
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational; one result register, no skid buffer).
REQ-017 SHALL present the result of an accepted symbol on out_valid/out_hit/out_run exactly one cycle after acceptance.
REQ-018 SHALL hold out_valid, out_hit, out_run stable while out_valid=1 and out_ready=0.
REQ-019 SHALL clear out_valid on a cycle with out_valid=1, out_ready=1 and no accept event; with a simultaneous accept, out_valid stays 1 and the new result replaces the old.
REQ-020 SHALL keep an internal run counter: on accept, hit increments it saturating at RUN_LEN, non-hit clears it to 0; no change without accept.
REQ-021 SHALL set out_run = 1 for a result whose updated run counter equals RUN_LEN; the alarm repeats on every further consecutive hit.
REQ-022 SHALL treat in_data as unsigned index into MASK; all 2**WIDTH values are legal.
REQ-023 SHALL ignore in_data when no accept event occurs (X-safe: X on in_data without accept shall not reach state).
REQ-024 SHALL implement the per-symbol membership test as a registered-output lookup of MASK only (no arithmetic decode).

Reset
REQ-025 SHALL on rst=1 at a clock edge set out_valid=0, out_hit=0, out_run=0, run counter=0, hit_count=0.
REQ-026 SHALL, with rst=1, hold in_ready=1 as a function of out_valid=0 but perform no accept; a symbol presented during reset is dropped.
REQ-027 SHALL discard any held result and partial run when reset is asserted mid-stream.

Configuration
REQ-028 SHALL compile the hit counter only when macro KEVIN_HIT_CNT_EN is defined: hit_count increments by 1 per accepted hit, saturating at 2**CNT_W-1.
REQ-029 SHALL, without KEVIN_HIT_CNT_EN, omit the hit_count port and counter; all other behaviour identical.

Structure
REQ-030 SHALL place default MASK constant (16'h56E2), default RUN_LEN, and the result record typedef (hit, run) in shared package kevin_pkg.
REQ-031 SHALL isolate the run/alarm tracking in sub-module kevin_run_ctr (inputs: accept, hit; output: run flag); lookup and handshake stay in kevin_stream.

Verification
REQ-032 SHALL cover: in_data swept 0..15 with out_ready=1, default params -> out_hit=1 exactly for 1,5,6,7,9,10,12,14, each one cycle after acceptance.
REQ-033 SHALL cover: stream 5,6,7,9,2,1 with out_ready=1 -> out_run 0,0,1,1,0,0.
REQ-034 SHALL cover: out_ready=0 for 4 cycles with result for 12 held -> in_ready=0, out_hit=1 stable, next symbol 3 accepted only after out_ready rises.
REQ-035 SHALL cover: rst asserted after symbols 1,5 accepted, then 6 -> out_run=0 for 6 (run restarted), hit_count=1 after 6 with KEVIN_HIT_CNT_EN.
REQ-036 SHALL cover: KEVIN_HIT_CNT_EN, CNT_W=2, five hits of symbol 10 -> hit_count 1,2,3,3,3.
REQ-037 SHALL cover: WIDTH=3, MASK=8'h81, RUN_LEN=1, symbols 0,7,3 -> out_hit 1,1,0 and out_run 1,1,0.
